// File: rtl/const_div_pipe.sv
// const_div_pipe: pipelined signed divide-by-constant with valid/ready handshake.
//
// Divides a signed WIDTH-bit dividend by the constant DIVISOR and returns an exact
// quotient and remainder with Verilog signed '/' and '%' semantics (truncation toward
// zero). The quotient comes from a fixed-point reciprocal multiply followed by one
// correction step.
//
// Pipeline: three register stages, so a result appears 3 cycles after acceptance when
// nothing stalls. A single global enable (en = !out_valid | out_ready) advances or
// holds every stage together. Bubbles travel as cleared stage valid flags.
//
// Optional build macro CONST_DIV_ROUND_EN: when defined, the last stage rounds the
// quotient to nearest with ties away from zero, and out_rem = in_data - out_quot*DIVISOR,
// so the remainder may have the opposite sign to the dividend. Latency does not change.
// With the macro undefined the block truncates toward zero.
//
// Parameters:
//   WIDTH    bit width of dividend, quotient and remainder
//   DIVISOR  positive constant divisor, 2 .. 2^(WIDTH-1)-1 (checked at elaboration)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset; clears all stage valids and the outputs
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle (combinational, equals the enable)
//   in_data    signed dividend
//   out_valid  out_quot/out_rem are valid
//   out_ready  downstream accepts the output
//   out_quot   signed quotient
//   out_rem    signed remainder

module const_div_pipe #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DIVISOR = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_quot,
   output logic signed [WIDTH-1:0] out_rem
);

   // Reciprocal fraction bits and full product width.
   localparam int unsigned SHIFT = WIDTH + $clog2(DIVISOR);
   localparam int unsigned PW    = WIDTH + SHIFT;

   localparam logic [PW-1:0] ONE_SH = PW'(1) << SHIFT;
   localparam logic [PW-1:0] RECIP  = ONE_SH / PW'(DIVISOR);
   localparam logic [PW-1:0] DIV_PW = PW'(DIVISOR);
   localparam logic [WIDTH-1:0] DIV_W = WIDTH'(DIVISOR);

   if ((DIVISOR < 2) || (64'(DIVISOR) > ((64'd1 << (WIDTH - 1)) - 64'd1))) begin : g_bad_divisor
      $error("const_div_pipe: DIVISOR out of range 2 .. 2^(WIDTH-1)-1");
   end

   logic en;

   // Stage 1: sign and magnitude.
   logic             v1_q;
   logic             neg1_q;
   logic [WIDTH-1:0] mag1_q;
   logic [WIDTH-1:0] mag1_d;

   // Stage 2: estimated quotient and remainder on magnitudes.
   logic             v2_q;
   logic             neg2_q;
   logic [WIDTH-1:0] q2_q;
   logic [WIDTH-1:0] r2_q;
   logic [PW-1:0]    prod;
   logic [PW-1:0]    q_times_d;
   logic [WIDTH-1:0] q_est;
   logic [WIDTH-1:0] r_est;

   // Stage 3: corrected, signed result.
   logic                    out_valid_q;
   logic signed [WIDTH-1:0] out_quot_q;
   logic signed [WIDTH-1:0] out_rem_q;
   logic [WIDTH-1:0]        q_mag;
   logic [WIDTH-1:0]        r_mag;
   logic signed [WIDTH-1:0] r_s;
   logic signed [WIDTH-1:0] quot_d;
   logic signed [WIDTH-1:0] rem_d;

   // Global enable: every stage moves together unless the output is blocked.
   always_comb begin
      en       = !out_valid_q || out_ready;
      in_ready = en;
   end

   // |in_data| as unsigned; the most negative value maps to 2^(WIDTH-1) without overflow.
   always_comb begin
      mag1_d = in_data[WIDTH-1] ? (~in_data + 1'b1) : in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
      end else if (en) begin
         v1_q <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (en && in_valid) begin
         neg1_q <= in_data[WIDTH-1];
         mag1_q <= mag1_d;
      end
   end

   // Reciprocal multiply. The estimate never exceeds the true quotient and is at most
   // one below it, so r_est lies in [0, 2*DIVISOR) and fits in WIDTH bits.
   always_comb begin
      prod      = PW'(mag1_q) * RECIP;
      q_est     = WIDTH'(prod >> SHIFT);
      q_times_d = PW'(q_est) * DIV_PW;
      r_est     = mag1_q - WIDTH'(q_times_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v2_q <= 1'b0;
      end else if (en) begin
         v2_q <= v1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (en && v1_q) begin
         neg2_q <= neg1_q;
         q2_q   <= q_est;
         r2_q   <= r_est;
      end
   end

   // Single correction step, optional rounding, then sign restoration.
   always_comb begin
      q_mag = q2_q;
      r_mag = r2_q;
      if (r2_q >= DIV_W) begin
         q_mag = q2_q + 1'b1;
         r_mag = r2_q - DIV_W;
      end
      // r_mag < DIVISOR < 2^(WIDTH-1), so the sign bit is clear.
      r_s = $signed(r_mag);
`ifdef CONST_DIV_ROUND_EN
      // Round half away from zero on magnitudes; remainder goes to (-DIVISOR, 0].
      if ({r_mag, 1'b0} >= (WIDTH + 1)'(DIVISOR)) begin
         q_mag = q_mag + 1'b1;
         r_s   = r_s - $signed(DIV_W);
      end
`endif
      quot_d = neg2_q ? $signed(~q_mag + 1'b1) : $signed(q_mag);
      rem_d  = neg2_q ? -r_s : r_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_quot_q  <= '0;
         out_rem_q   <= '0;
      end else if (en) begin
         out_valid_q <= v2_q;
         if (v2_q) begin
            out_quot_q <= quot_d;
            out_rem_q  <= rem_d;
         end
      end
   end

   always_comb begin
      out_valid = out_valid_q;
      out_quot  = out_quot_q;
      out_rem   = out_rem_q;
   end

endmodule

// File: tb/tb_const_div_pipe.sv
// Self-checking bench for const_div_pipe. Several instances with different WIDTH and
// DIVISOR run side by side; a scoreboard queue holds expected results computed from
// plain integer division, and one monitor compares each presented output.

module tb_const_div_pipe;

   localparam int NI     = 6;
   localparam int WS [NI] = '{8, 8, 8, 8, 8, 16};
   localparam int DS [NI] = '{3, 7, 10, 127, 2, 1000};
   localparam int NSWEEP = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [NI-1:0] in_valid;
   logic [NI-1:0] in_ready;
   logic [NI-1:0] out_valid;
   logic [NI-1:0] out_ready;
   logic [15:0]   in_data [NI];
   int            oq [NI];
   int            orm [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int W = WS[g];
      logic [W-1:0] q_w;
      logic [W-1:0] r_w;
      const_div_pipe #(
         .WIDTH   (W),
         .DIVISOR (DS[g])
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g][W-1:0]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_quot  (q_w),
         .out_rem   (r_w)
      );
      assign oq[g]  = int'($signed(q_w));
      assign orm[g] = int'($signed(r_w));
   end

   typedef struct {
      int inst;
      int a;
      int q;
      int r;
      int cyc;
      int holds;
   } exp_t;

   exp_t sb[$];
   int   n_chk;
   int   n_fail;
   int   cyc;
   int   holds [NI];
   bit   held [NI];
   bit   presented [NI];
   bit   after_rst [NI];
   int   hq [NI];
   int   hr [NI];

   // Sign-extend the low w bits of a.
   function automatic int fit(input int a, input int w);
      int s = 32 - w;
      return (a <<< s) >>> s;
   endfunction

   // Reference division from integer arithmetic.
   function automatic void ref_div(input int a, input int d, output int q, output int r);
      q = a / d;
      r = a % d;
`ifdef CONST_DIV_ROUND_EN
      if (2 * (r < 0 ? -r : r) >= d) q = q + ((a < 0) ? -1 : 1);
      r = a - q * d;
`endif
   endfunction

   task automatic check(input bit ok, input string name, input int i, input int act,
                        input int exp);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s inst%0d (W=%0d D=%0d): got %0d, expected %0d",
                  name, i, WS[i], DS[i], act, exp);
      end
   endtask

   // Monitor and scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].inst == i) sb.delete(k);
            held[i]      = 1'b0;
            presented[i] = 1'b0;
            after_rst[i] = 1'b1;
         end else begin
            int idx;
            if (after_rst[i]) begin
               check(out_valid[i] == 1'b0, "reset_out_valid", i, int'(out_valid[i]), 0);
               check(oq[i] == 0, "reset_out_quot", i, oq[i], 0);
               check(orm[i] == 0, "reset_out_rem", i, orm[i], 0);
               check(in_ready[i] == 1'b1, "reset_in_ready", i, int'(in_ready[i]), 1);
               after_rst[i] = 1'b0;
            end
            if (held[i]) begin
               check(out_valid[i] == 1'b1, "stall_valid", i, int'(out_valid[i]), 1);
               check(oq[i] == hq[i], "stall_quot", i, oq[i], hq[i]);
               check(orm[i] == hr[i], "stall_rem", i, orm[i], hr[i]);
            end
            if (out_valid[i]) begin
               idx = -1;
               for (int k = 0; k < sb.size(); k++) begin
                  if (sb[k].inst == i) begin
                     idx = k;
                     break;
                  end
               end
               check(idx >= 0, "spurious_out_valid", i, 1, 0);
               if (idx >= 0) begin
                  check(oq[i] == sb[idx].q, "quot", i, oq[i], sb[idx].q);
                  check(orm[i] == sb[idx].r, "rem", i, orm[i], sb[idx].r);
                  if (!presented[i] && sb[idx].holds == holds[i])
                     check(cyc - sb[idx].cyc == 3, "latency", i, cyc - sb[idx].cyc, 3);
                  presented[i] = 1'b1;
                  if (out_ready[i]) begin
                     sb.delete(idx);
                     presented[i] = 1'b0;
                  end
               end
            end
            if (out_valid[i] && !out_ready[i]) begin
               held[i] = 1'b1;
               hq[i]   = oq[i];
               hr[i]   = orm[i];
               holds[i]++;
            end else begin
               held[i] = 1'b0;
            end
            if (in_valid[i] && in_ready[i]) begin
               exp_t e;
               e.inst  = i;
               e.a     = fit(int'($signed(in_data[i])), WS[i]);
               ref_div(e.a, DS[i], e.q, e.r);
               e.cyc   = cyc;
               e.holds = holds[i];
               sb.push_back(e);
            end
         end
      end
   end

   task automatic drain();
      int n = 0;
      in_valid  = '0;
      out_ready = '1;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      check(sb.size() == 0, "drain_outstanding", 0, sb.size(), 0);
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic send_all(input int v);
      for (int i = 0; i < NI; i++) begin
         in_valid[i] = 1'b1;
         in_data[i]  = 16'(v);
      end
      @(posedge clk);
      #1;
   endtask

   int dir [17] = '{7, -7, 127, -128, 0, 8, -8, 4, 3, -3, 9, 1, -1, 32767, -32768, 999, -1000};
   int ptr [NI];

   initial begin
      bit all_done;
      int iter;
      rst       = 1'b1;
      in_valid  = '0;
      out_ready = '1;
      for (int i = 0; i < NI; i++) in_data[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed values back-to-back with out_ready held high.
      foreach (dir[k]) send_all(dir[k]);
      drain();

      // Full sweep (random for the 16-bit instance) with random bubbles and backpressure.
      for (int i = 0; i < NI; i++) ptr[i] = 0;
      iter     = 0;
      all_done = 1'b0;
      while (!all_done && iter < 8000) begin
         for (int i = 0; i < NI; i++) begin
            out_ready[i] = ($urandom_range(0, 3) != 0);
            if (ptr[i] < NSWEEP && $urandom_range(0, 4) != 0) begin
               in_valid[i] = 1'b1;
               if (WS[i] == 8) in_data[i] = 16'(ptr[i] - 128);
               else if (ptr[i] == 0) in_data[i] = 16'h7fff;
               else if (ptr[i] == 1) in_data[i] = 16'h8000;
               else in_data[i] = 16'($urandom_range(0, 65535));
            end else begin
               in_valid[i] = 1'b0;
            end
         end
         @(negedge clk);
         for (int i = 0; i < NI; i++) if (in_valid[i] && in_ready[i]) ptr[i]++;
         @(posedge clk);
         #1;
         iter++;
         all_done = 1'b1;
         for (int i = 0; i < NI; i++) if (ptr[i] < NSWEEP) all_done = 1'b0;
      end
      check(all_done, "sweep_complete", 0, iter, NSWEEP);
      drain();

      // Reset with transactions in flight; the input offered during reset is dropped.
      out_ready = '0;
      send_all(11);
      send_all(-20);
      send_all(50);
      rst = 1'b1;
      send_all(55);
      rst       = 1'b0;
      in_valid  = '0;
      out_ready = '1;
      repeat (5) @(posedge clk);
      #1;
      send_all(9);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "timeout");
   end

endmodule
